parity_frame_tx: RTL
====================

// Module: parity_frame_tx
// PURPOSE
//   Downstream consumer of the 7-bit XOR parity stage.
//   - Accepts a data word over a valid/ready handshake.
//   - Computes the word's parity internally, using the same function as the parity stage: XOR of all bits.
//   - Serialises a framed bit stream: start, data LSB-first, parity, stop. One bit per clock.
//   - Feeds the serial link toward the CGP-evaluated receiver.
// PARAMETERS
//   DATA_W  7  payload width in bits (>=1)
//   ODD     0  0: parity bit = ^data (even); 1: parity bit = ~^data (odd)
// PORTS
//   clk       in   1       single clock, rising edge
//   rst_n     in   1       synchronous, active-low reset
//   in_data   in   DATA_W  payload word; sampled only on accept edge
//   in_valid  in   1       upstream has a word
//   in_ready  out  1       block can accept a word this cycle
//   tx_bit    out  1       serial line; idle level 1
//   tx_busy   out  1       1 while a frame (start..stop) is on tx_bit
//   frame_done out 1       1-cycle pulse during the stop bit
// BEHAVIOUR
//   - One clock, clk. Reset is synchronous, active-low, on rst_n. All state is updated on rising clk.
//   - Reset (rst_n=0 at edge) forces:
//     - state=IDLE; tx_bit=1, tx_busy=0, frame_done=0;
//     - in_ready=0 while rst_n=0.
//   - Accept: in_valid & in_ready at a rising edge (edge E0). On accept the block latches:
//     - in_data into shift register;
//     - parity = ^in_data ^ ODD.
//   - Outputs are registered. Relative to E0, cycle k is the period after edge E0+k:
//     - cycle 1: START, tx_bit=0
//     - cycles 2..DATA_W+1: DATA, tx_bit=data[k-2], LSB first
//     - cycle DATA_W+2: PARITY, tx_bit=parity
//     - cycle DATA_W+3: STOP, tx_bit=1, frame_done=1
//   - Frame length is DATA_W+3 cycles; default 10.
//   - tx_busy=1 in cycles 1..DATA_W+3.
//   - FSM: IDLE -> START -> DATA (bit counter 0..DATA_W-1) -> PARITY -> STOP.
//     - STOP -> START if an accept happened at the STOP edge, else IDLE.
//   - in_ready = rst_n & (state==IDLE | state==STOP). This is combinational from state.
//     - Back-to-back frames therefore have no idle gap.
//   - in_valid while busy (not ready) is ignored. in_data may change freely until the accept edge.
//   - IDLE: tx_bit=1, tx_busy=0, frame_done=0.
//   - Reset mid-frame aborts the frame:
//     - next cycle tx_bit=1; no frame_done;
//     - latched word discarded;
//     - in_ready=1 on the first cycle rst_n=1.
//   - Bit counter width is $clog2(DATA_W). It never wraps past DATA_W-1.
// TESTING
//   T1 reset: hold rst_n=0 for 3 cycles, in_valid=1 -> tx_bit=1, tx_busy=0, in_ready=0, frame_done=0.
//      After release: in_ready=1.
//   T2 single frame, in_data=7'h55 -> tx_bit over cycles 1..10 = 0,1,0,1,0,1,0,1,0,1.
//      Parity bit is 0. frame_done=1 only in cycle 10. Then IDLE, tx_bit=1.
//   T3 exhaustive: in_data=0..127 -> for each frame, the bit captured at cycle 9 equals a[0]^..^a[6].
//      Captured bits 2..8 reproduce in_data.
//   T4 back-to-back: in_valid held, 7'h01 then 7'h7F -> second START lands in the cycle right after the first STOP.
//      Second frame's parity bit is 1. in_ready is high only in IDLE/STOP.
//   T5 abort: rst_n=0 for one edge during cycle 5 of a 7'h2A frame -> tx_bit=1 next cycle.
//      No frame_done. A new word is accepted right after release and sent correctly.
//   T6 ODD=1: in_data=7'h00 -> parity bit 1. in_data=7'h01 -> parity bit 0.

Source files
------------

// File: rtl/parity_frame_tx.sv
// +----------------------------------------------------------------------------+
// | parity_frame_tx: serialises a framed word (start, data LSB-first, parity,  |
// | stop) after a valid/ready accept, one bit per clock.    Revision: 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module parity_frame_tx #(
  parameter int DATA_W = 7,
  parameter int ODD    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic              ODD_BIT  = (ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_bit_q, tx_bit_d;
  logic              tx_busy_q, tx_busy_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] shifted;
  logic              accept;

  assign in_ready = rst_n & ((state_q == IDLE) | (state_q == STOP));
  assign accept   = in_valid & in_ready;
  assign shifted  = shift_q >> 1;

  // Outputs are computed for the state being entered, so they appear one
  // cycle after the edge that makes the transition.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tx_bit_d     = 1'b1;
    tx_busy_d    = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: ;
      START: begin
        state_d   = DATA;
        cnt_d     = '0;
        tx_bit_d  = shift_q[0];
        tx_busy_d = 1'b1;
      end
      DATA: begin
        tx_busy_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d  = PARITY;
          tx_bit_d = parity_q;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          shift_d  = shifted;
          tx_bit_d = shifted[0];
        end
      end
      PARITY: begin
        state_d      = STOP;
        tx_busy_d    = 1'b1;
        frame_done_d = 1'b1;
      end
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Accept is only possible in IDLE or STOP; STOP chains straight into START.
    if (accept) begin
      state_d   = START;
      shift_d   = in_data;
      parity_d  = (^in_data) ^ ODD_BIT;
      tx_bit_d  = 1'b0;
      tx_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tx_bit_q     <= 1'b1;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tx_bit_q     <= tx_bit_d;
      tx_busy_q    <= tx_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_bit     = tx_bit_q;
  assign tx_busy    = tx_busy_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire
